sign_config_ctrl: RTL and testbench
===================================

SIGN_CONFIG_CTRL -- requirements
Module: sign_config_ctrl

Interface
REQ-001 SHALL have parameter BRICKS, default 4: number of 2-bit bricks per operand; power of two, >= 2.
REQ-002 SHALL have derived parameter WW = log2(BRICKS)+2, default 4: width of the one-hot precision code, where bit k means 2^k bits.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  in  1  a new configuration is offered.
REQ-006 SHALL have port cfg_ready  out  1  the shadow register can accept a configuration.
REQ-007 SHALL have port cfg_in_width  in  WW  one-hot input-activation precision.
REQ-008 SHALL have port cfg_weight_width  in  WW  one-hot weight precision.
REQ-009 SHALL have port cfg_in_sgn_en  in  1  1 = inputs are signed; 0 = unsigned.
REQ-010 SHALL have port cfg_weight_sgn_en  in  1  1 = weights are signed; 0 = unsigned.
REQ-011 SHALL have port commit  in  1  layer-boundary pulse; moves shadow to active.
REQ-012 SHALL have port err_clear  in  1  clears the sticky error flag.
REQ-013 SHALL have port in_signed  out  BRICKS  per-brick sign mask for inputs, registered.
REQ-014 SHALL have port weight_signed  out  BRICKS  per-brick sign mask for weights, registered.
REQ-015 SHALL have port active_valid  out  1  active masks hold a committed configuration.
REQ-016 SHALL have port pending  out  1  the shadow register holds an uncommitted configuration.
REQ-017 SHALL have port cfg_error  out  1  sticky flag: an illegal width was offered.

Function
REQ-018 A configuration SHALL transfer only on a cycle with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL equal ~pending.
REQ-019 A width code SHALL be legal only if exactly one bit is set; zero or multi-hot codes SHALL be illegal.
REQ-020 A transfer with any illegal width SHALL be dropped: shadow and pending unchanged, cfg_error set to 1 on the next edge.
REQ-021 A legal transfer SHALL load the shadow (both widths and both sgn_en bits) and set pending=1 on the same edge.
REQ-022 The state machine SHALL have two states: EMPTY (pending=0) and LOADED (pending=1).
  - EMPTY -> LOADED on a legal transfer.
  - LOADED -> EMPTY on commit.
  - All other inputs SHALL hold the current state.
REQ-023 A commit while in EMPTY SHALL be ignored; the active masks are unchanged.
REQ-024 A commit while in LOADED SHALL, on that edge, register the decoded shadow into in_signed/weight_signed and set active_valid=1.
  - Latency: new masks are visible one cycle after commit is sampled.
REQ-025 Mask decode for width 2^k with k <= 1 (1- or 2-bit) SHALL be all ones.
REQ-026 Mask decode for k >= 2 SHALL use group G = 2^(k-1) bricks; mask bit i = 1 iff (i mod G) == G-1, so the MSB brick of each group is signed.
REQ-027 If the corresponding sgn_en bit is 0, that operand's mask SHALL be all zeros regardless of width.
REQ-028 Because cfg_ready=0 in LOADED, commit and a new transfer SHALL never coincide.
  - The cycle after commit, cfg_ready=1.
REQ-029 err_clear SHALL clear cfg_error on the next edge.
  - If err_clear coincides with a new illegal transfer, cfg_error SHALL remain 1 (set wins).
REQ-030 Active masks SHALL hold their value indefinitely between commits, including while a new configuration is pending.

Reset
REQ-031 Asserting reset SHALL immediately force:
  - in_signed=0, weight_signed=0
  - active_valid=0, pending=0, cfg_error=0
  - cfg_ready=1
  - state EMPTY, shadow cleared.
REQ-032 Reset asserted mid-operation with a pending configuration SHALL discard the pending configuration; no commit takes effect after release.

Verification
REQ-033 BRICKS=4: transfer in_width=0100, weight_width=1000, both sgn_en=1, then commit -> one cycle later in_signed=1010, weight_signed=1000, active_valid=1, pending=0.
REQ-034 BRICKS=4: transfer in_width=0001, weight_width=0010, cfg_in_sgn_en=0, then commit -> in_signed=0000, weight_signed=1111.
REQ-035 BRICKS=8 (WW=5): transfer widths 01000 and 10000 with sgn_en=1, then commit -> in_signed=10001000, weight_signed=10000000.
REQ-036 Offer in_width=0110 -> cfg_error=1, pending stays 0, masks unchanged; err_clear -> cfg_error=0; err_clear together with another illegal offer -> cfg_error stays 1.
REQ-037 Load configuration A and commit; load B without commit -> masks still show A and cfg_ready=0; commit -> B; a second commit while EMPTY -> masks unchanged.
REQ-038 Load B (pending=1), then pulse reset asynchronously mid-cycle -> all outputs 0 and cfg_ready=1 immediately; a later commit does not change the masks.

Source files
------------

// File: rtl/sign_config_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sign_config_ctrl_if
// Brief    : Configuration handshake, commit/clear controls and the resulting
//            per-brick sign masks shared by sign_config_ctrl and its driver.
// Revision : 1.0
// ============================================================================
interface sign_config_ctrl_if #(
    parameter int BRICKS = 4
);
    localparam int WW = $clog2(BRICKS) + 2;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [WW-1:0]     cfg_in_width;
    logic [WW-1:0]     cfg_weight_width;
    logic              cfg_in_sgn_en;
    logic              cfg_weight_sgn_en;
    logic              commit;
    logic              err_clear;
    logic [BRICKS-1:0] in_signed;
    logic [BRICKS-1:0] weight_signed;
    logic              active_valid;
    logic              pending;
    logic              cfg_error;

    modport master (
        output cfg_valid, cfg_in_width, cfg_weight_width,
               cfg_in_sgn_en, cfg_weight_sgn_en, commit, err_clear,
        input  cfg_ready, in_signed, weight_signed,
               active_valid, pending, cfg_error
    );

    modport slave (
        input  cfg_valid, cfg_in_width, cfg_weight_width,
               cfg_in_sgn_en, cfg_weight_sgn_en, commit, err_clear,
        output cfg_ready, in_signed, weight_signed,
               active_valid, pending, cfg_error
    );
endinterface
`default_nettype wire

// File: rtl/sign_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sign_config_ctrl
// Brief    : Shadow/active precision configuration with per-brick sign-mask
//            decode, committed at layer boundaries, sticky illegal-width flag.
// Revision : 1.0
// ============================================================================
module sign_config_ctrl #(
    parameter int BRICKS = 4
) (
    input  wire             clk,
    input  wire             reset,
    sign_config_ctrl_if.slave cfg
);
    localparam int WW = $clog2(BRICKS) + 2;

    localparam logic [0:0] S_EMPTY  = 1'b0;
    localparam logic [0:0] S_LOADED = 1'b1;

    // Width 2^k with k>=2 spans 2^(k-1) bricks; only the top brick carries sign.
    function automatic logic [BRICKS-1:0] f_decode(input logic [WW-1:0] w,
                                                   input logic        sgn);
        logic [BRICKS-1:0] m;
        m = '0;
        if (sgn) begin
            if (w[0] | w[1]) begin
                m = '1;
            end else begin
                for (int k = 2; k < WW; k++) begin
                    if (w[k]) begin
                        for (int i = 0; i < BRICKS; i++) begin
                            m[i] = ((i % (1 << (k - 1))) == ((1 << (k - 1)) - 1));
                        end
                    end
                end
            end
        end
        return m;
    endfunction

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [WW-1:0]     r_sh_in_width;
    logic [WW-1:0]     r_sh_weight_width;
    logic              r_sh_in_sgn;
    logic              r_sh_weight_sgn;
    logic [BRICKS-1:0] r_in_mask;
    logic [BRICKS-1:0] r_weight_mask;
    logic              r_active_valid;
    logic              r_cfg_error;

    logic              w_pending;
    logic              w_ready;
    logic              w_xfer;
    logic              w_legal;
    logic              w_load;
    logic              w_bad;
    logic              w_commit_go;

    assign w_xfer  = cfg.cfg_valid & w_ready;
    assign w_legal = $onehot(cfg.cfg_in_width) & $onehot(cfg.cfg_weight_width);
    assign w_load  = w_xfer & w_legal;
    assign w_bad   = w_xfer & ~w_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY:  if (w_load)     w_state_nxt = S_LOADED;
            S_LOADED: if (cfg.commit) w_state_nxt = S_EMPTY;
            default:                  w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        w_pending   = (r_state == S_LOADED);
        w_ready     = ~w_pending;
        w_commit_go = w_pending & cfg.commit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_in_width     <= '0;
            r_sh_weight_width <= '0;
            r_sh_in_sgn       <= 1'b0;
            r_sh_weight_sgn   <= 1'b0;
        end else if (w_load) begin
            r_sh_in_width     <= cfg.cfg_in_width;
            r_sh_weight_width <= cfg.cfg_weight_width;
            r_sh_in_sgn       <= cfg.cfg_in_sgn_en;
            r_sh_weight_sgn   <= cfg.cfg_weight_sgn_en;
        end
    end

    // Active masks change only on a commit that finds a loaded shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_mask      <= '0;
            r_weight_mask  <= '0;
            r_active_valid <= 1'b0;
        end else if (w_commit_go) begin
            r_in_mask      <= f_decode(r_sh_in_width, r_sh_in_sgn);
            r_weight_mask  <= f_decode(r_sh_weight_width, r_sh_weight_sgn);
            r_active_valid <= 1'b1;
        end
    end

    // Setting takes priority over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_error <= 1'b0;
        end else if (w_bad) begin
            r_cfg_error <= 1'b1;
        end else if (cfg.err_clear) begin
            r_cfg_error <= 1'b0;
        end
    end

    assign cfg.cfg_ready     = w_ready;
    assign cfg.pending       = w_pending;
    assign cfg.in_signed     = r_in_mask;
    assign cfg.weight_signed = r_weight_mask;
    assign cfg.active_valid  = r_active_valid;
    assign cfg.cfg_error     = r_cfg_error;

endmodule
`default_nettype wire

// File: tb/tb_sign_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sign_config_ctrl
// Brief    : Directed self-checking bench for sign_config_ctrl (BRICKS=4 and 8).
// Revision : 1.0
// ============================================================================
module tb_sign_config_ctrl;
    typedef struct packed {
        logic [7:0] in_m;
        logic [7:0] w_m;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t e;

    sign_config_ctrl_if #(.BRICKS(4)) if4 ();
    sign_config_ctrl_if #(.BRICKS(8)) if8 ();

    sign_config_ctrl #(.BRICKS(4)) u_dut4 (.clk(clk), .reset(reset), .cfg(if4.slave));
    sign_config_ctrl #(.BRICKS(8)) u_dut8 (.clk(clk), .reset(reset), .cfg(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic offer4(input logic [3:0] iw, input logic [3:0] ww,
                          input logic isg, input logic wsg);
        @(negedge clk);
        if4.cfg_valid         = 1'b1;
        if4.cfg_in_width      = iw;
        if4.cfg_weight_width  = ww;
        if4.cfg_in_sgn_en     = isg;
        if4.cfg_weight_sgn_en = wsg;
        @(negedge clk);
        if4.cfg_valid = 1'b0;
    endtask

    task automatic commit4;
        @(negedge clk);
        if4.commit = 1'b1;
        @(negedge clk);
        if4.commit = 1'b0;
    endtask

    task automatic clear4;
        @(negedge clk);
        if4.err_clear = 1'b1;
        @(negedge clk);
        if4.err_clear = 1'b0;
    endtask

    task automatic check_sb4(input string tag);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_in"}, 8'(if4.in_signed), e.in_m);
            chk({tag, "_wt"}, 8'(if4.weight_signed), e.w_m);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        {if4.cfg_valid, if4.commit, if4.err_clear, if4.cfg_in_sgn_en, if4.cfg_weight_sgn_en} = '0;
        if4.cfg_in_width = '0; if4.cfg_weight_width = '0;
        {if8.cfg_valid, if8.commit, if8.err_clear, if8.cfg_in_sgn_en, if8.cfg_weight_sgn_en} = '0;
        if8.cfg_in_width = '0; if8.cfg_weight_width = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_in",    8'(if4.in_signed), 8'h00);
        chk("rst_wt",    8'(if4.weight_signed), 8'h00);
        chk("rst_av",    8'(if4.active_valid), 8'h0);
        chk("rst_pend",  8'(if4.pending), 8'h0);
        chk("rst_err",   8'(if4.cfg_error), 8'h0);
        chk("rst_ready", 8'(if4.cfg_ready), 8'h1);

        // 4-bit signed inputs / 8-bit signed weights
        offer4(4'b0100, 4'b1000, 1'b1, 1'b1);
        sb.push_back('{in_m: 8'b1010, w_m: 8'b1000});
        chk("ld_pend",  8'(if4.pending), 8'h1);
        chk("ld_ready", 8'(if4.cfg_ready), 8'h0);
        chk("ld_av",    8'(if4.active_valid), 8'h0);
        commit4;
        check_sb4("c1");
        chk("c1_av",    8'(if4.active_valid), 8'h1);
        chk("c1_pend",  8'(if4.pending), 8'h0);
        chk("c1_ready", 8'(if4.cfg_ready), 8'h1);

        // Narrow widths, unsigned inputs
        offer4(4'b0001, 4'b0010, 1'b0, 1'b1);
        sb.push_back('{in_m: 8'b0000, w_m: 8'b1111});
        commit4;
        check_sb4("c2");

        offer4(4'b0010, 4'b0100, 1'b1, 1'b1);
        sb.push_back('{in_m: 8'b1111, w_m: 8'b1010});
        commit4;
        check_sb4("c3");

        offer4(4'b1000, 4'b1000, 1'b1, 1'b0);
        sb.push_back('{in_m: 8'b1000, w_m: 8'b0000});
        commit4;
        check_sb4("c4");

        // BRICKS=8 instance
        @(negedge clk);
        if8.cfg_valid = 1'b1; if8.cfg_in_width = 5'b01000; if8.cfg_weight_width = 5'b10000;
        if8.cfg_in_sgn_en = 1'b1; if8.cfg_weight_sgn_en = 1'b1;
        @(negedge clk);
        if8.cfg_valid = 1'b0; if8.commit = 1'b1;
        @(negedge clk);
        if8.commit = 1'b0;
        chk("b8_in", if8.in_signed, 8'b10001000);
        chk("b8_wt", if8.weight_signed, 8'b10000000);
        if8.cfg_valid = 1'b1; if8.cfg_in_width = 5'b00100; if8.cfg_weight_width = 5'b00010;
        @(negedge clk);
        if8.cfg_valid = 1'b0; if8.commit = 1'b1;
        @(negedge clk);
        if8.commit = 1'b0;
        chk("b8_in2", if8.in_signed, 8'b10101010);
        chk("b8_wt2", if8.weight_signed, 8'b11111111);

        // Illegal widths: multi-hot, then zero
        offer4(4'b0110, 4'b0100, 1'b1, 1'b1);
        chk("ill_err",  8'(if4.cfg_error), 8'h1);
        chk("ill_pend", 8'(if4.pending), 8'h0);
        chk("ill_in",   8'(if4.in_signed), 8'b1000);
        chk("ill_wt",   8'(if4.weight_signed), 8'b0000);
        clear4;
        chk("clr_err",  8'(if4.cfg_error), 8'h0);
        offer4(4'b0100, 4'b0000, 1'b1, 1'b1);
        chk("zero_err",  8'(if4.cfg_error), 8'h1);
        chk("zero_pend", 8'(if4.pending), 8'h0);
        @(negedge clk);
        if4.err_clear = 1'b1;
        if4.cfg_valid = 1'b1; if4.cfg_in_width = 4'b1100; if4.cfg_weight_width = 4'b0001;
        @(negedge clk);
        if4.err_clear = 1'b0; if4.cfg_valid = 1'b0;
        chk("setwin_err", 8'(if4.cfg_error), 8'h1);
        clear4;
        chk("clr2_err", 8'(if4.cfg_error), 8'h0);

        // A committed, B pending, offer while loaded is refused
        offer4(4'b0100, 4'b1000, 1'b1, 1'b1);
        sb.push_back('{in_m: 8'b1010, w_m: 8'b1000});
        commit4;
        check_sb4("ca");
        offer4(4'b1000, 4'b0001, 1'b1, 1'b1);
        chk("b_hold_in", 8'(if4.in_signed), 8'b1010);
        chk("b_hold_wt", 8'(if4.weight_signed), 8'b1000);
        chk("b_ready",   8'(if4.cfg_ready), 8'h0);
        offer4(4'b0001, 4'b0100, 1'b0, 1'b0);
        chk("b_refuse_err", 8'(if4.cfg_error), 8'h0);
        sb.push_back('{in_m: 8'b1000, w_m: 8'b1111});
        commit4;
        check_sb4("cb");
        chk("cb_ready", 8'(if4.cfg_ready), 8'h1);
        sb.push_back('{in_m: 8'b1000, w_m: 8'b1111});
        commit4;
        check_sb4("c_empty");
        chk("c_empty_pend", 8'(if4.pending), 8'h0);

        // Asynchronous reset with a pending configuration
        offer4(4'b0100, 4'b0100, 1'b1, 1'b1);
        chk("pre_rst_pend", 8'(if4.pending), 8'h1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_in",    8'(if4.in_signed), 8'h00);
        chk("arst_wt",    8'(if4.weight_signed), 8'h00);
        chk("arst_av",    8'(if4.active_valid), 8'h0);
        chk("arst_pend",  8'(if4.pending), 8'h0);
        chk("arst_ready", 8'(if4.cfg_ready), 8'h1);
        chk("arst_b8",    if8.in_signed, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        sb.push_back('{in_m: 8'b0000, w_m: 8'b0000});
        commit4;
        check_sb4("post_rst");
        chk("post_rst_av", 8'(if4.active_valid), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
